// File: rtl/seg_scan_driver_if.sv
// Bundles the BCD/time input side and the seven-segment output side of the
// scan driver so the producer and the display driver share one connection.
interface seg_scan_driver_if;
  logic [31:0] disp_data;
  logic [7:0]  dp_mask;
  logic        lz_en;
  logic [7:0]  an;
  logic [7:0]  seg0;
  logic [7:0]  seg1;
  logic        frame_done;

  modport master (
    output disp_data, dp_mask, lz_en,
    input  an, seg0, seg1, frame_done
  );

  modport slave (
    input  disp_data, dp_mask, lz_en,
    output an, seg0, seg1, frame_done
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Scans an 8-digit display as two 4-digit groups, one digit per group per phase,
// from a per-frame snapshot with blanking, leading-zero suppression and dps.
module seg_scan_driver #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic             clk,
  input  logic             rst,
  seg_scan_driver_if.slave bus
);
  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX   = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] BLANK_END = DW'(BLANK_CYC);

  logic [DW-1:0] div;
  logic [1:0]    phase;
  logic [31:0]   sh_data;
  logic [7:0]    sh_dp;
  logic          sh_lz;
  logic          snap;

  logic [3:0]    nib [8];
  logic [7:0]    blank;
  logic          tail_zero;
  logic [3:0]    onehot;
  logic [2:0]    lo_idx;
  logic [2:0]    hi_idx;
  logic [7:0]    an_n;
  logic [7:0]    seg0_n;
  logic [7:0]    seg1_n;

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 7'h3F;
      4'h1: enc = 7'h06;
      4'h2: enc = 7'h5B;
      4'h3: enc = 7'h4F;
      4'h4: enc = 7'h66;
      4'h5: enc = 7'h6D;
      4'h6: enc = 7'h7D;
      4'h7: enc = 7'h07;
      4'h8: enc = 7'h7F;
      4'h9: enc = 7'h6F;
      4'hA: enc = 7'h77;
      4'hB: enc = 7'h7C;
      4'hC: enc = 7'h39;
      4'hD: enc = 7'h5E;
      4'hE: enc = 7'h79;
      default: enc = 7'h71;
    endcase
  endfunction

  // The last clock of phase 3 closes the frame and loads the next snapshot.
  assign snap = (phase == 2'd3) && (div == DIV_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div            <= '0;
      phase          <= 2'd0;
      sh_data        <= '0;
      sh_dp          <= '0;
      sh_lz          <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      if (div == DIV_MAX) begin
        div   <= '0;
        phase <= phase + 2'd1;
      end else begin
        div <= div + 1'b1;
      end
      if (snap) begin
        sh_data <= bus.disp_data;
        sh_dp   <= bus.dp_mask;
        sh_lz   <= bus.lz_en;
      end
      bus.frame_done <= snap;
    end
  end

  // Digits are blanked from the top down while every nibble above is zero;
  // enables stay on for blank digits so brightness timing is unchanged.
  always_comb begin
    tail_zero = 1'b1;
    blank     = '0;
    an_n      = '0;
    seg0_n    = '0;
    seg1_n    = '0;
    onehot    = 4'b0001 << phase;
    lo_idx    = {1'b0, phase};
    hi_idx    = {1'b1, phase};
    for (int k = 7; k >= 0; k--) begin
      nib[k]    = sh_data[4*k +: 4];
      tail_zero = tail_zero & (nib[k] == 4'h0);
      blank[k]  = sh_lz & tail_zero & (k != 0);
    end
    if (div >= BLANK_END) begin
      an_n   = {onehot, onehot};
      seg0_n = {sh_dp[lo_idx], blank[lo_idx] ? 7'h00 : enc(nib[lo_idx])};
      seg1_n = {sh_dp[hi_idx], blank[hi_idx] ? 7'h00 : enc(nib[hi_idx])};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.an   <= '0;
      bus.seg0 <= '0;
      bus.seg1 <= '0;
    end else begin
      bus.an   <= an_n;
      bus.seg0 <= seg0_n;
      bus.seg1 <= seg1_n;
    end
  end
endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Display-side consumer for the timekeeping block's BCD time output. Drives the board's 8-digit seven-segment display, organised as two 4-digit groups with separate segment buses and a shared 8-bit digit-enable bus. Scans four phases, lighting one digit per group per phase. Each frame uses a tear-free snapshot of the input data, with inter-digit blanking, optional leading-zero suppression, and per-digit decimal points.

Parameters:
SCAN_DIV, 100000, clocks per scan phase (1 ms at 100 MHz, 250 Hz frame); legal range >= 2.
BLANK_CYC, 1000, clocks at the start of each phase with all digits off (anti-ghosting); legal range BLANK_CYC < SCAN_DIV.

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  reset, asynchronous, active-high
disp_data  in  32  eight hex/BCD nibbles; digit k = disp_data[4k+3:4k], digit 0 rightmost
dp_mask  in  8  bit k lights decimal point of digit k
lz_en  in  1  1 = suppress leading zeros
an  out  8  digit enables, active-high; an[3:0] = group 0 (seg0), an[7:4] = group 1 (seg1)
seg0  out  8  group-0 segments {dp,g,f,e,d,c,b,a}, active-high
seg1  out  8  group-1 segments, same encoding
frame_done  out  1  one-clock pulse per completed frame

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-high on rst.
- Reset state:
  - div=0, phase=0.
  - Shadow data/dp/lz = 0.
  - an=0, seg0=0, seg1=0, frame_done=0.
  - Asserting rst mid-frame forces all of these immediately, without waiting for a clock.
- Phase counter:
  - div counts 0..SCAN_DIV-1.
  - At div==SCAN_DIV-1, div wraps to 0 and phase advances 0→1→2→3→0 (2-bit wrap).
- Snapshot:
  - On the clock where phase==3 and div==SCAN_DIV-1, disp_data, dp_mask and lz_en are captured into shadow registers.
  - Input changes at any other time do not affect the display until the next snapshot.
  - The first frame after reset shows the reset shadow (zeros).
- frame_done: registered, high for exactly one clock, in the cycle following the snapshot edge. Period is 4*SCAN_DIV clocks.
- Output generation (registered; one clock of latency from the div/phase state):
  - When div < BLANK_CYC: an=0, seg0=0, seg1=0.
  - Otherwise: an = (1<<phase) | (1<<(phase+4)); seg0 = enc(digit phase); seg1 = enc(digit phase+4).
- enc, segment bits [6:0] per nibble:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - bit 7 = shadow dp_mask[k].
- Leading-zero suppression:
  - Digit k (1..7) is blank when shadow lz is set and shadow nibbles k..7 are all zero.
  - A blank digit drives segment bits [6:0]=0, but its dp bit is still honoured.
  - Digit 0 is never blanked.
  - The enable bit for a blank digit is still asserted (constant brightness timing).
- No other state; no handshake on inputs (level-sampled at snapshot only).

Test Plan:
Bench uses SCAN_DIV=8, BLANK_CYC=2 (frame = 32 clocks).
1. Reset, async:
   - Assert rst between clock edges → an, seg0, seg1 and frame_done read 0 before the next edge.
   - Release rst → first frame shows 3F on all digits during lit windows (lz=0); frame_done first pulses 32 clocks after release.
2. Decode and scan:
   - Drive disp_data=32'h12345678, dp_mask=0, lz_en=0; wait one snapshot.
   - Phase 0 lit window: an=8'h11, seg0=7F, seg1=66.
   - Phase 1: an=8'h22, seg0=07, seg1=4F.
   - Phase 3: an=8'h88, seg0=6D, seg1=06.
3. Blanking: in every phase, the first 2 output cycles have an=0, seg0=0, seg1=0; the remaining 6 cycles hold a steady value.
4. Tear-free snapshot:
   - Change disp_data from 12345678 to FFFFFFFF at phase 1, div 4.
   - Phases 1–3 of that frame still show 12345678 values.
   - The next frame shows 71 on all digits.
5. Leading-zero suppression:
   - disp_data=32'h00000105, lz_en=1 → digits 3..7 seg bits [6:0] = 00; digit2=06, digit1=3F, digit0=6D.
   - disp_data=0 → only digit 0 shows 3F.
6. Decimal point on a blanked digit:
   - disp_data=0, lz_en=1, dp_mask=8'h84.
   - Phase 3: seg1=80.
   - Phase 2: seg0=80.
   - frame_done is one clock wide every 32 clocks throughout.
